branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences the branch compare unit's result into a front-end redirect for the NPC pipeline. Each cycle the EX stage presents a valid branch op, the block samples the BCU's `jump_branch`/`dnpc` outputs and decides whether to redirect. The static prediction is not-taken. On a taken branch it latches the target, flushes the wrong-path stages, and holds a valid/ready redirect request until the IFU accepts it. It also keeps saturating branch and taken counters for performance reporting.

## Interface
Parameters:
- `XLEN`, 64: PC/target width (matches `RegBus`).
- `BCUOP_W`, 3: BCU opcode width (matches `bcuopLength`).
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ex_valid_i_brc`, input, 1: the EX stage holds a valid instruction this cycle.
- `bcuop_i_brc`, input, BCUOP_W: BCU opcode of the EX instruction; nonzero means branch-type.
- `jump_branch_i_brc`, input, 1: BCU taken result.
- `dnpc_i_brc`, input, XLEN: BCU target, pc + offset.
- `ifu_ready_i_brc`, input, 1: IFU accepts a redirect this cycle.
- `redirect_valid_o_brc`, output, 1: a redirect request is pending.
- `redirect_pc_o_brc`, output, XLEN: the latched target.
- `flush_o_brc`, output, 1: one-cycle pulse that kills the IF/ID contents.
- `stall_o_brc`, output, 1: holds ID/EX; EX results are ignored while high.
- `misalign_o_brc`, output, 1: one-cycle pulse for a taken branch whose target is misaligned.
- `branch_cnt_o_brc`, output, CNT_W: number of branch ops evaluated.
- `taken_cnt_o_brc`, output, CNT_W: number of taken branch ops.

## Operation
- Event `br` = `ex_valid & (bcuop != 0)`. Event `tk` = `br & jump_branch`. Both are sampled only in IDLE.
- States and transitions:
  - IDLE:
    - `tk` with `dnpc[1:0]==0`: latch `dnpc` into `redirect_pc`, go to REDIR.
    - `tk` with `dnpc[1:0]!=0`: pulse `misalign` next cycle, stay in IDLE, no redirect.
    - Otherwise stay in IDLE.
  - REDIR:
    - `redirect_valid=1`, `stall=1`.
    - `flush=1` only on the first REDIR cycle.
    - `redirect_valid & ifu_ready`: go to DRAIN.
    - Otherwise stay in REDIR, with `redirect_pc` held stable.
  - DRAIN:
    - `stall=1`, `redirect_valid=0`; exactly one cycle, so the wrong-path EX slot is discarded.
    - Then go to IDLE.
- All `ex_valid`/`bcuop`/`jump_branch` activity outside IDLE is wrong-path: it is ignored and not counted.
- Counters:
  - `branch_cnt` increments on `br` in IDLE.
  - `taken_cnt` increments on `tk` in IDLE, including misaligned targets.
  - Both saturate at all-ones.
- State encoding is internal; an illegal state recovers to IDLE on the next clock with all outputs 0.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset (asserted, async): state=IDLE; `redirect_valid`, `flush`, `stall`, `misalign` all 0; `redirect_pc`=0; both counters=0. Effective immediately, not on the next edge.
- Reset asserted during REDIR or DRAIN abandons the redirect; no request survives reset.
- Taken branch sampled at cycle T:
  - T+1: `redirect_valid`, `flush`, `stall` all 1.
  - If `ifu_ready` is high at T+1: DRAIN at T+2, IDLE at T+3.
  - A new branch can be sampled at T+3 at the earliest.
- `ifu_ready` low for N cycles extends REDIR by N cycles. `flush` still pulses only once; `redirect_pc` is unchanged throughout.
- `ifu_ready` is ignored while `redirect_valid=0`.
- Not-taken or non-branch: no state change; counters update at T+1.
- Misaligned taken branch at T: `misalign=1` at T+1 only; `stall`/`flush` stay 0.
- Counter at all-ones plus an increment event: the value holds.

## Test plan
- Reset then idle: after `rst_n` rises, drive `ex_valid=1`, `bcuop=0` for 5 cycles -> all outputs 0 and both counters 0.
- Taken, immediate accept: at T, `bcuop=3'b001`, `jump_branch=1`, `dnpc=0x8000_0040`, `ifu_ready=1` -> at T+1 `redirect_valid=flush=stall=1`, `redirect_pc=0x8000_0040`; T+2 `stall=1` only; T+3 all 0; `branch_cnt=1`, `taken_cnt=1`.
- Backpressure: same stimulus with `ifu_ready=0` for 3 cycles -> `redirect_valid` high for 4 cycles, `flush` high only at T+1. Meanwhile drive a second taken branch with `dnpc=0x8000_1000` -> it is ignored, `redirect_pc` stays 0x8000_0040, `taken_cnt=1`.
- Not-taken then misaligned: a branch with `jump_branch=0` -> `branch_cnt=1`, `taken_cnt=0`, no stall. Then a taken branch with `dnpc=0x8000_0042` -> `misalign` pulses for 1 cycle, no redirect, `taken_cnt=1`.
- Reset mid-redirect: drop `rst_n` while in REDIR with `ifu_ready=0` -> all outputs 0 immediately; after release, no redirect reappears.
- Saturation: preload via 2^CNT_W-1 branch events (or CNT_W=4 with 15 events), then one more -> `branch_cnt` stays all-ones.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Turns a taken BCU result into a held redirect request for the IFU.
// It also flushes the wrong-path stages and keeps saturating branch/taken counters.
module branch_redirect_ctrl #(
  parameter int XLEN    = 64,
  parameter int BCUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid_i_brc,
  input  logic [BCUOP_W-1:0] bcuop_i_brc,
  input  logic               jump_branch_i_brc,
  input  logic [XLEN-1:0]    dnpc_i_brc,
  input  logic               ifu_ready_i_brc,
  output logic               redirect_valid_o_brc,
  output logic [XLEN-1:0]    redirect_pc_o_brc,
  output logic               flush_o_brc,
  output logic               stall_o_brc,
  output logic               misalign_o_brc,
  output logic [CNT_W-1:0]   branch_cnt_o_brc,
  output logic [CNT_W-1:0]   taken_cnt_o_brc
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REDIR = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t state;

  logic br;
  logic tk;
  logic tk_aligned;
  logic tk_misaligned;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign br            = ex_valid_i_brc & (|bcuop_i_brc);
  assign tk            = br & jump_branch_i_brc;
  assign tk_aligned    = tk & (dnpc_i_brc[1:0] == 2'b00);
  assign tk_misaligned = tk & (dnpc_i_brc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      redirect_valid_o_brc <= 1'b0;
      redirect_pc_o_brc    <= '0;
      flush_o_brc          <= 1'b0;
      stall_o_brc          <= 1'b0;
      misalign_o_brc       <= 1'b0;
      branch_cnt_o_brc     <= '0;
      taken_cnt_o_brc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only IDLE samples EX; everything seen in REDIR/DRAIN is wrong-path.
          redirect_valid_o_brc <= tk_aligned;
          flush_o_brc          <= tk_aligned;
          stall_o_brc          <= tk_aligned;
          misalign_o_brc       <= tk_misaligned;
          if (br) branch_cnt_o_brc <= sat_inc(branch_cnt_o_brc);
          if (tk) taken_cnt_o_brc  <= sat_inc(taken_cnt_o_brc);
          if (tk_aligned) begin
            redirect_pc_o_brc <= dnpc_i_brc;
            state             <= REDIR;
          end
        end
        REDIR: begin
          flush_o_brc    <= 1'b0;
          misalign_o_brc <= 1'b0;
          stall_o_brc    <= 1'b1;
          if (redirect_valid_o_brc && ifu_ready_i_brc) begin
            redirect_valid_o_brc <= 1'b0;
            state                <= DRAIN;
          end
        end
        DRAIN: begin
          redirect_valid_o_brc <= 1'b0;
          flush_o_brc          <= 1'b0;
          misalign_o_brc       <= 1'b0;
          stall_o_brc          <= 1'b0;
          state                <= IDLE;
        end
        default: begin
          redirect_valid_o_brc <= 1'b0;
          flush_o_brc          <= 1'b0;
          stall_o_brc          <= 1'b0;
          misalign_o_brc       <= 1'b0;
          state                <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, reset/saturation sequences,
// and randomized traffic against a cycle-level reference model.
module tb_branch_redirect_ctrl;

  localparam int XLEN    = 64;
  localparam int BCUOP_W = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               ex_valid;
  logic [BCUOP_W-1:0] bcuop;
  logic               jump_branch;
  logic [XLEN-1:0]    dnpc;
  logic               ifu_ready;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               flush;
  logic               stall;
  logic               misalign;
  logic [CNT_W-1:0]   branch_cnt;
  logic [CNT_W-1:0]   taken_cnt;

  int checks;
  int failures;

  branch_redirect_ctrl #(
    .XLEN(XLEN), .BCUOP_W(BCUOP_W), .CNT_W(CNT_W)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex_valid_i_brc       (ex_valid),
    .bcuop_i_brc          (bcuop),
    .jump_branch_i_brc    (jump_branch),
    .dnpc_i_brc           (dnpc),
    .ifu_ready_i_brc      (ifu_ready),
    .redirect_valid_o_brc (redirect_valid),
    .redirect_pc_o_brc    (redirect_pc),
    .flush_o_brc          (flush),
    .stall_o_brc          (stall),
    .misalign_o_brc       (misalign),
    .branch_cnt_o_brc     (branch_cnt),
    .taken_cnt_o_brc      (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               ev;
    logic [BCUOP_W-1:0] op;
    logic               jb;
    logic [XLEN-1:0]    pc;
    logic               rdy;
    logic [3:0]         flags;  // {redirect_valid, flush, stall, misalign}
    logic [XLEN-1:0]    exp_pc;
    logic [CNT_W-1:0]   exp_b;
    logic [CNT_W-1:0]   exp_t;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ev, input logic [BCUOP_W-1:0] op, input logic jb,
                              input logic [XLEN-1:0] pc, input logic rdy, input logic [3:0] flags,
                              input logic [XLEN-1:0] exp_pc, input logic [CNT_W-1:0] exp_b,
                              input logic [CNT_W-1:0] exp_t);
    vec_t v;
    v.ev = ev; v.op = op; v.jb = jb; v.pc = pc; v.rdy = rdy;
    v.flags = flags; v.exp_pc = exp_pc; v.exp_b = exp_b; v.exp_t = exp_t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] flags, input logic [XLEN-1:0] pc,
                         input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] t);
    chk({tag, ".redirect_valid"}, XLEN'(redirect_valid), XLEN'(flags[3]));
    chk({tag, ".flush"},          XLEN'(flush),          XLEN'(flags[2]));
    chk({tag, ".stall"},          XLEN'(stall),          XLEN'(flags[1]));
    chk({tag, ".misalign"},       XLEN'(misalign),       XLEN'(flags[0]));
    chk({tag, ".redirect_pc"},    redirect_pc,           pc);
    chk({tag, ".branch_cnt"},     XLEN'(branch_cnt),     XLEN'(b));
    chk({tag, ".taken_cnt"},      XLEN'(taken_cnt),      XLEN'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [BCUOP_W-1:0] op, input logic jb,
                       input logic [XLEN-1:0] pc, input logic rdy);
    ex_valid = ev; bcuop = op; jump_branch = jb; dnpc = pc; ifu_ready = rdy;
  endtask

  // Reference model: next observable outputs derived from the current ones.
  logic            m_rv, m_fl, m_st, m_mis;
  logic [XLEN-1:0] m_pc;
  int              m_b, m_t;

  task automatic model_reset();
    m_rv = 1'b0; m_fl = 1'b0; m_st = 1'b0; m_mis = 1'b0; m_pc = '0; m_b = 0; m_t = 0;
  endtask

  task automatic model_step(input logic ev, input logic [BCUOP_W-1:0] op, input logic jb,
                            input logic [XLEN-1:0] pc, input logic rdy);
    bit is_br, is_tk;
    is_br = ev && (op != 0);
    is_tk = is_br && jb;
    m_fl  = 1'b0;
    m_mis = 1'b0;
    if (m_rv) begin
      if (rdy) m_rv = 1'b0;
    end else if (m_st) begin
      m_st = 1'b0;
    end else begin
      if (is_br && m_b < CNT_MAX) m_b++;
      if (is_tk && m_t < CNT_MAX) m_t++;
      if (is_tk) begin
        if (pc[1:0] == 2'b00) begin
          m_rv = 1'b1; m_fl = 1'b1; m_st = 1'b1; m_pc = pc;
        end else begin
          m_mis = 1'b1;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive(1'b0, 3'd0, 1'b0, 64'h0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_all("reset", 4'b0000, 64'h0, 4'd0, 4'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Directed table: idle, immediate accept, backpressure, not-taken, misaligned.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1'b1, 3'd0, 1'b1, 64'h8000_0040, 1'b1, 4'b0000, 64'h0, 4'd0, 4'd0));
    vecs.push_back(mk(1'b1, 3'd1, 1'b1, 64'h8000_0040, 1'b1, 4'b1110, 64'h8000_0040, 4'd1, 4'd1));
    vecs.push_back(mk(1'b1, 3'd1, 1'b1, 64'h8000_1000, 1'b1, 4'b0010, 64'h8000_0040, 4'd1, 4'd1));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 64'h0,         1'b1, 4'b0000, 64'h8000_0040, 4'd1, 4'd1));
    vecs.push_back(mk(1'b1, 3'd1, 1'b1, 64'h8000_0040, 1'b0, 4'b1110, 64'h8000_0040, 4'd2, 4'd2));
    vecs.push_back(mk(1'b1, 3'd1, 1'b1, 64'h8000_1000, 1'b0, 4'b1010, 64'h8000_0040, 4'd2, 4'd2));
    vecs.push_back(mk(1'b1, 3'd5, 1'b1, 64'h8000_1000, 1'b0, 4'b1010, 64'h8000_0040, 4'd2, 4'd2));
    vecs.push_back(mk(1'b1, 3'd1, 1'b1, 64'h8000_1000, 1'b0, 4'b1010, 64'h8000_0040, 4'd2, 4'd2));
    vecs.push_back(mk(1'b1, 3'd1, 1'b1, 64'h8000_1000, 1'b1, 4'b0010, 64'h8000_0040, 4'd2, 4'd2));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 64'h0,         1'b1, 4'b0000, 64'h8000_0040, 4'd2, 4'd2));
    vecs.push_back(mk(1'b1, 3'd2, 1'b0, 64'h8000_2000, 1'b0, 4'b0000, 64'h8000_0040, 4'd3, 4'd2));
    vecs.push_back(mk(1'b1, 3'd1, 1'b1, 64'h8000_0042, 1'b1, 4'b0001, 64'h8000_0040, 4'd4, 4'd3));
    vecs.push_back(mk(1'b0, 3'd1, 1'b1, 64'h8000_0080, 1'b1, 4'b0000, 64'h8000_0040, 4'd4, 4'd3));
    vecs.push_back(mk(1'b1, 3'd0, 1'b1, 64'h8000_0080, 1'b0, 4'b0000, 64'h8000_0040, 4'd4, 4'd3));

    foreach (vecs[i]) begin
      drive(vecs[i].ev, vecs[i].op, vecs[i].jb, vecs[i].pc, vecs[i].rdy);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].flags, vecs[i].exp_pc, vecs[i].exp_b, vecs[i].exp_t);
    end

    // Reset while the redirect is stalled by the IFU.
    drive(1'b1, 3'd3, 1'b1, 64'h8000_0100, 1'b0);
    tick();
    chk_all("pre_rst", 4'b1110, 64'h8000_0100, 4'd5, 4'd4);
    drive(1'b0, 3'd0, 1'b0, 64'h0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 4'b0000, 64'h0, 4'd0, 4'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("post_rst", 4'b0000, 64'h0, 4'd0, 4'd0);
    end

    // Saturation of both counters.
    drive(1'b1, 3'd4, 1'b0, 64'h0, 1'b0);
    repeat (CNT_MAX) tick();
    chk_all("sat_b_full", 4'b0000, 64'h0, 4'hF, 4'd0);
    tick();
    chk_all("sat_b_hold", 4'b0000, 64'h0, 4'hF, 4'd0);
    drive(1'b1, 3'd1, 1'b1, 64'h8000_0003, 1'b0);
    repeat (CNT_MAX + 1) tick();
    chk_all("sat_t_hold", 4'b0001, 64'h0, 4'hF, 4'hF);

    // Randomized traffic, reset periodically so counters stay informative.
    for (int blk = 0; blk < 6; blk++) begin
      drive(1'b0, 3'd0, 1'b0, 64'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 60; c++) begin
        logic               r_ev, r_jb, r_rdy;
        logic [BCUOP_W-1:0] r_op;
        logic [XLEN-1:0]    r_pc;
        r_ev  = ($urandom_range(0, 3) != 0);
        r_op  = ($urandom_range(0, 2) == 0) ? 3'd0 : BCUOP_W'($urandom_range(1, 7));
        r_jb  = 1'($urandom_range(0, 1));
        r_pc  = {32'h8000_0000, $urandom()};
        if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
        r_rdy = ($urandom_range(0, 2) != 0);
        drive(r_ev, r_op, r_jb, r_pc, r_rdy);
        tick();
        model_step(r_ev, r_op, r_jb, r_pc, r_rdy);
        chk_all("rand", {m_rv, m_fl, m_st, m_mis}, m_pc, CNT_W'(m_b), CNT_W'(m_t));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
